div_seq: RTL and testbench

Multi-cycle sequencer for the integer divide resource, used by the EX stage for DIV/DIVU.
- EX presents operands and holds start_i; this block runs a 32-step restoring division and stalls the pipeline until done.
- It then returns a 64-bit {remainder, quotient} for HI/LO writeback.
- Annul (exception/flush) aborts an operation in flight.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 159 +++++++++++++++
 tb/tb_div_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage <-> divide sequencer bundle.
// Master drives the request, slave returns the result.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i,
    output opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i,
    input  opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU.
// Returns {remainder, quotient}; stalls EX while busy.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BY_ZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               sgn1_q, sgn1_d;
  logic               sgn2_q, sgn2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               accept;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH:0]     part;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] step_w;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept  = bus.start_i & ~bus.annul_i;
  assign op1_abs = (bus.signed_div_i & bus.opdata1_i[WIDTH-1])
                 ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i & bus.opdata2_i[WIDTH-1])
                 ? -bus.opdata2_i : bus.opdata2_i;

  // Partial remainder keeps the bit shifted out of rem so no
  // information is lost for divisors with the top bit set.
  assign part   = work_q[2*WIDTH-1:WIDTH-1];
  assign diff   = {1'b0, part} - {2'b00, dvsr_q};
  assign step_w = diff[WIDTH+1]
                ? {part[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                : {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  assign quo_fix = (sgn1_q ^ sgn2_q) ? -step_w[WIDTH-1:0]
                                     : step_w[WIDTH-1:0];
  assign rem_fix = sgn1_q ? -step_w[2*WIDTH-1:WIDTH]
                          : step_w[2*WIDTH-1:WIDTH];

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FREE: begin
        if (accept) begin
          state_d = (bus.opdata2_i == '0) ? S_BY_ZERO : S_ON;
        end
      end
      S_BY_ZERO: state_d = S_END;
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (ready_q && !bus.start_i) begin
          state_d = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  // Datapath and output register updates per state.
  always_comb begin
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (accept && (bus.opdata2_i != '0)) begin
          dvsr_d = op2_abs;
          work_d = {{WIDTH{1'b0}}, op1_abs};
          cnt_d  = '0;
          sgn1_d = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
          sgn2_d = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        end
      end
      S_BY_ZERO: begin
        ready_d  = 1'b0;
        result_d = '0;
      end
      S_ON: begin
        if (bus.annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          cnt_d    = '0;
        end else begin
          work_d = step_w;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      S_END: begin
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (!bus.start_i) begin
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq.
// Arithmetic reference model plus cycle-exact latency checks.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;

  div_seq_if #(.WIDTH(32)) bus_if ();

  div_seq #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] exp_res;
  logic        exp_valid = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic [31:0] q;
    logic [31:0] r;
    longint sa;
    longint sb;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Result must match the model whenever the DUT claims it is ready.
  always @(negedge clk) begin
    if (!rst && bus_if.ready_o) begin
      if (exp_valid) chk("result", bus_if.result_o, exp_res);
      else chk("unexpected_ready", 64'(bus_if.ready_o), 64'd0);
    end
  end

  task automatic run_div(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic s,
                         input logic [63:0] hand,
                         input int hold);
    int lat;
    int sc;
    logic [63:0] m;
    m = model(a, b, s);
    chk("model_pin", m, hand);
    lat = (b == 32'd0) ? 2 : 33;
    bus_if.opdata1_i    = a;
    bus_if.opdata2_i    = b;
    bus_if.signed_div_i = s;
    bus_if.start_i      = 1'b1;
    @(posedge clk);
    exp_res   = m;
    exp_valid = 1'b1;
    sc = 0;
    @(negedge clk);
    if (bus_if.stallreq_o) sc++;
    chk("ready_e0", 64'(bus_if.ready_o), 64'd0);
    bus_if.opdata1_i = $urandom;
    bus_if.opdata2_i = $urandom;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < lat) begin
        if (bus_if.stallreq_o) sc++;
        chk("busy_ready", 64'(bus_if.ready_o), 64'd0);
      end else begin
        chk("ready_rise", 64'(bus_if.ready_o), 64'd1);
        chk("stall_fall", 64'(bus_if.stallreq_o), 64'd0);
      end
    end
    chk("stall_cycles", 64'(sc), 64'(lat));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", 64'(bus_if.ready_o), 64'd1);
      chk("hold_result", bus_if.result_o, m);
    end
    bus_if.start_i = 1'b0;
    @(negedge clk);
    exp_valid = 1'b0;
    chk("free_ready", 64'(bus_if.ready_o), 64'd0);
    chk("free_result", bus_if.result_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    bus_if.start_i      = 1'b0;
    bus_if.annul_i      = 1'b0;
    bus_if.signed_div_i = 1'b0;
    bus_if.opdata1_i    = '0;
    bus_if.opdata2_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus_if.ready_o), 64'd0);
    chk("rst_result", bus_if.result_o, 64'd0);
    chk("rst_stall", 64'(bus_if.stallreq_o), 64'd0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 0);
    run_div(32'd5, 32'd0, 1'b0, 64'h0, 0);
    run_div(32'd5, 32'd0, 1'b1, 64'h0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0);
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 0);
    run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 0);

    // Annul on step 10, then an immediate new request.
    bus_if.opdata1_i    = 32'd100;
    bus_if.opdata2_i    = 32'd7;
    bus_if.signed_div_i = 1'b0;
    bus_if.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 bus_if.annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall", 64'(bus_if.stallreq_o), 64'd0);
    @(posedge clk);
    #1 bus_if.annul_i = 1'b0;
    @(negedge clk);
    chk("annul_ready", 64'(bus_if.ready_o), 64'd0);
    chk("annul_result", bus_if.result_o, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0);

    // Reset in the middle of an operation.
    bus_if.opdata1_i    = 32'd100;
    bus_if.opdata2_i    = 32'd7;
    bus_if.signed_div_i = 1'b0;
    bus_if.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst            = 1'b1;
    bus_if.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ready", 64'(bus_if.ready_o), 64'd0);
    chk("mid_rst_result", bus_if.result_o, 64'd0);
    chk("mid_rst_stall", 64'(bus_if.stallreq_o), 64'd0);
    rst = 1'b0;
    run_div(32'h12345678, 32'h00001000, 1'b0,
            64'h00000678_00012345, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
